// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: ROM address/data, redirect, enable and the decode-side valid/ready head port.
interface fetch_queue_if #(
    parameter int DEPTH = 8
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          fetch_en;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_instr;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;
    logic          fetch_done;

    modport master (
        input  fetch_en, imem_instr, redirect, redirect_pc, out_ready,
        output imem_addr, out_valid, out_pc, out_instr, count, fetch_done
    );

    modport slave (
        output fetch_en, imem_instr, redirect, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_pc, out_instr, count, fetch_done
    );
endinterface

// File: rtl/fetch_queue.sv
// PC register feeding a combinational ROM, captured {pc, instr} into a DEPTH-entry ring; 1-cycle fetch-to-valid.
// Backpressure: a full ring stalls the PC unless the head pops the same cycle; redirect flushes and restarts.
module fetch_queue #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_BYTES = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          ring [DEPTH];
    logic [31:0]     pc;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            full;
    logic            push;
    logic            pop;
    logic            fetch_done;
    logic            out_valid;

    assign fetch_done = (pc >= 32'(MEM_BYTES));
    assign full       = (count == CW'(DEPTH));
    // The head is hidden during a redirect so the consumer never pops a flushed entry.
    assign out_valid  = (count != '0) & ~bus.redirect;
    assign pop        = out_valid & bus.out_ready;
    assign push       = bus.fetch_en & ~bus.redirect & ~fetch_done & (~full | pop);

    assign bus.imem_addr  = pc;
    assign bus.out_valid  = out_valid;
    assign bus.out_pc     = ring[head].pc;
    assign bus.out_instr  = ring[head].instr;
    assign bus.count      = count;
    assign bus.fetch_done = fetch_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.redirect) begin
            pc    <= {bus.redirect_pc[31:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
                pc   <= pc + 32'd4;
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage has no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            ring[tail] <= '{pc: pc, instr: bus.imem_instr};
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int DEPTH = 8;
    localparam int MEMB  = 1024;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH(DEPTH), .RESET_PC(32'h0), .MEM_BYTES(MEMB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.master)
    );

    logic [31:0] rom [MEMB/4];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < MEMB) return rom[a[9:2]];
        return 32'hBAD0_BAD0;
    endfunction

    always_comb bus.imem_instr = rom_word(bus.imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mpc;
    bit          known;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the queue model, advance the model.
    task automatic cyc(input bit rn, input bit fen, input bit rd, input logic [31:0] rpc, input bit rdy);
        bit ev, pp, ph, done;
        reset_n         = rn;
        bus.fetch_en    = fen;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.out_ready   = rdy;
        #1;
        done = (mpc >= MEMB);
        ev   = (q.size() != 0) && !rd;
        if (known) begin
            chk("imem_addr", bus.imem_addr, mpc);
            chk("count", 32'(bus.count), 32'(q.size()));
            chk("fetch_done", 32'(bus.fetch_done), 32'(done));
            chk("out_valid", 32'(bus.out_valid), 32'(ev));
            if (ev) begin
                chk("out_pc", bus.out_pc, q[0].pc);
                chk("out_instr", bus.out_instr, q[0].instr);
            end
        end
        if (!rn) begin
            q.delete();
            mpc   = 32'h0;
            known = 1'b1;
        end else if (rd) begin
            q.delete();
            mpc = rpc & ~32'h3;
        end else begin
            pp = ev && rdy;
            ph = fen && !done && (q.size() < DEPTH || pp);
            if (pp) void'(q.pop_front());
            if (ph) begin
                q.push_back('{pc: mpc, instr: rom_word(mpc)});
                mpc = mpc + 4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        known = 1'b0;
        mpc   = 32'h0;
        for (int i = 0; i < MEMB/4; i++) rom[i] = $urandom;

        // Reset then stream
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        chk("first_not_yet_valid", 32'(bus.count), 32'd1);
        for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 1);
        chk("stream_count", 32'(bus.count), 32'd1);

        // Backpressure fill, then full push+pop, then drain/refill
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0);
        chk("fill_count", 32'(bus.count), 32'd8);
        chk("fill_addr", bus.imem_addr, 32'd32);
        cyc(1, 1, 0, 0, 1);
        chk("full_pp_count", 32'(bus.count), 32'd8);
        chk("full_pp_addr", bus.imem_addr, 32'd36);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 1);

        // Redirect mid-stream with a misaligned target
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
        chk("pre_redirect_count", 32'(bus.count), 32'd5);
        cyc(1, 1, 1, 32'h46, 1);
        chk("redirect_addr", bus.imem_addr, 32'h44);
        chk("redirect_count", 32'(bus.count), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 1);

        // End of memory, then resume from 0
        cyc(1, 1, 1, 32'd1016, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
        chk("eom_addr", bus.imem_addr, 32'd1024);
        chk("eom_done", 32'(bus.fetch_done), 32'd1);
        chk("eom_count", 32'(bus.count), 32'd2);
        cyc(1, 1, 1, 32'd0, 1);
        chk("resume_done", 32'(bus.fetch_done), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 1);

        // Reset with a full queue and a concurrent redirect
        for (int i = 0; i < 9; i++) cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 1, 32'h80, 1);
        chk("rst_over_redirect_addr", bus.imem_addr, 32'h0);
        chk("rst_over_redirect_count", 32'(bus.count), 32'd0);
        chk("rst_over_redirect_valid", 32'(bus.out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) >= 2),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 99) < 5),
                32'($urandom_range(0, 1100)),
                ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Front-end fetch stage of the out-of-order core. Holds the program counter, drives the word address into the combinational instruction ROM and captures the returned word together with its PC into a small FIFO. Decode/dispatch drains the FIFO through a valid/ready handshake. A redirect from branch resolution or commit flushes the queue and restarts fetch at a new PC.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0: PC loaded on reset; word-aligned.
- MEM_BYTES, 1024: instruction ROM size in bytes; fetch stops at this bound.

- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset; sampled on posedge clk.
- fetch_en  in  1  global fetch enable; 0 = no new fetches, queue still drains.
- imem_addr  out  32  byte address to ROM; always equals the PC register.
- imem_instr  in  32  ROM read data, combinational from imem_addr.
- redirect  in  1  flush queue and load redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0).
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head this cycle.
- out_pc  out  32  PC of head entry.
- out_instr  out  32  instruction word of head entry.
- count  out  $clog2(DEPTH+1)  occupied entries.
- fetch_done  out  1  PC ≥ MEM_BYTES; no further fetches until redirect.

## Operation
- State: pc (32b), circular buffer of DEPTH {pc, instr} entries, head/tail pointers (log2 DEPTH bits, wrap naturally), count.
- imem_addr = pc, purely from the register; no combinational path from any input.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect & ~fetch_done & ((count < DEPTH) | pop). A push into a full queue is allowed only when a pop happens the same cycle.
- On push: write {pc, imem_instr} at tail, tail+1, pc <= pc + 4 (32-bit add, no overflow handling).
- On pop: head+1.
- count_next = count + push − pop; never exceeds DEPTH nor goes below 0.
- fetch_done = (pc ≥ MEM_BYTES), combinational from pc. The ROM is never addressed past its end while pushing.
- out_valid = (count ≠ 0) & ~redirect. The head is suppressed in the redirect cycle, so no pop occurs then.
- out_pc/out_instr = entry at head; don't-care when out_valid = 0.
- Redirect (priority over everything except reset): head <= 0, tail <= 0, count <= 0, pc <= {redirect_pc[31:2], 2'b00}. No push or pop that cycle.
- Reset (priority over redirect): pc <= RESET_PC, head/tail/count <= 0. Entry storage is not cleared.

## Timing
- After reset release, imem_addr = RESET_PC in the first cycle. First entry is pushed at the end of that cycle if fetch_en = 1. out_valid rises the following cycle (1-cycle fetch-to-valid latency).
- Steady state with out_ready = 1 and fetch_en = 1: one push and one pop per cycle; count holds at 1.
- Redirect at cycle N: out_valid = 0 in cycle N. In cycle N+1, imem_addr = redirect_pc and count = 0. The first redirected entry is valid in cycle N+2.
- Full (count = DEPTH) with out_ready = 0: pc holds, imem_addr stable, no push.
- Reset mid-operation: state returns to reset values on that posedge regardless of other inputs. out_valid = 0, count = 0, fetch_done = 0 in the next cycle (assuming RESET_PC < MEM_BYTES).
- The head entry and its output fields are stable while out_valid = 1 and out_ready = 0.

## Test plan
- Reset then stream: reset_n low 2 cycles, fetch_en = 1, out_ready = 1. Expect out_pc sequence 0, 4, 8, … one per cycle, each out_instr = ROM word at out_pc/4, first valid on the 2nd cycle after release.
- Backpressure fill: out_ready = 0 from reset. Expect count to reach 8 after 8 cycles, imem_addr to hold at 32, then out_ready = 1 pops PCs 0…28 in order while refilling at 32, 36, …
- Full with simultaneous push/pop: count = 8, out_ready = 1 one cycle. Expect count to stay 8, head PC to advance by 4, pc to advance by 4.
- Redirect mid-stream: count = 5, redirect = 1, redirect_pc = 32'h46 (misaligned). Expect out_valid = 0 that cycle, count = 0 and imem_addr = 32'h44 next cycle, first out_pc = 32'h44 the cycle after.
- End of memory: redirect_pc = 1016. Expect pushes at 1016 and 1020, then fetch_done = 1 with pc = 1024 and no further pushes. A redirect to 0 clears fetch_done and resumes fetch.
- Reset during full queue and concurrent redirect: expect pc = RESET_PC, count = 0, out_valid = 0 on the next cycle, with the redirect ignored.
